lab3_seq_ctrl: RTL and testbench
================================

LAB3_SEQ_CTRL -- requirements
Module: lab3_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYC, default 1, datapath settle cycles per code, legal range 1..15.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, sweep request, sampled on the rising edge of CLK in IDLE only.
REQ-005 The block SHALL have port abort, input, 1, terminates an active sweep.
REQ-006 The block SHALL have port start_code, input, 3, first code to apply.
REQ-007 The block SHALL have port end_code, input, 3, last code to apply.
REQ-008 The block SHALL have port dp_out, input, 4, result returned by the combinational 3-in/4-out datapath.
REQ-009 The block SHALL have port dp_in, output, 3, registered code driving datapath inputs {in2,in1,in0}.
REQ-010 The block SHALL have port res_valid, output, 1, one-cycle strobe qualifying res_code/res_data.
REQ-011 The block SHALL have port res_code, output, 3, code that produced res_data.
REQ-012 The block SHALL have port res_data, output, 4, captured dp_out.
REQ-013 The block SHALL have port sum, output, 7, running unsigned sum of captured results in the current sweep.
REQ-014 The block SHALL have port n_res, output, 4, number of results captured in the current sweep (0..8).
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1, high exactly while in state DONE.

Function
REQ-017 The state machine SHALL have states IDLE, SETTLE, CAPTURE, DONE; busy and done SHALL decode from the state register.
REQ-018 In IDLE with start=1 and abort=0 at the rising edge of CLK: dp_in<=start_code, latch end_code internally, sum<=0, n_res<=0, wait counter<=0, next state SETTLE.
REQ-019 In IDLE, start=0 or abort=1 SHALL keep IDLE with all outputs held.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles; the wait counter increments each cycle, and when it equals SETTLE_CYC-1 the next state is CAPTURE.
REQ-021 Leaving CAPTURE SHALL do: res_data<=dp_out, res_code<=dp_in, res_valid<=1, sum<=sum+dp_out, n_res<=n_res+1.
REQ-022 Leaving CAPTURE with dp_in equal to the latched end_code SHALL go to DONE with dp_in held; otherwise dp_in<=dp_in+1 modulo 8, wait counter<=0, next state SETTLE.
REQ-023 Wrap-around: end_code<start_code SHALL sweep through 7 to 0 (e.g. 6,7,0,1); start_code==end_code SHALL sweep exactly one code.
REQ-024 Per-code latency SHALL be SETTLE_CYC+1 cycles; a sweep of N codes SHALL have its last res_valid N*(SETTLE_CYC+1) edges after the start edge, in the same cycle as done.
REQ-025 res_valid SHALL be high for exactly one cycle per captured code and low otherwise.
REQ-026 DONE SHALL last one cycle, then IDLE; sum, n_res, res_code, res_data and dp_in SHALL hold until the next accepted start.
REQ-027 abort=1 in SETTLE, CAPTURE or DONE SHALL force IDLE at the next edge with no capture, res_valid=0, done never asserted for that sweep, and dp_in/sum/n_res held; abort SHALL have priority over capture.
REQ-028 start asserted while busy=1 SHALL be ignored and SHALL NOT restart or extend the sweep.
REQ-029 sum SHALL NOT overflow (maximum 8*15=120); no saturation logic is required.

Reset
REQ-030 RST_N=0 SHALL immediately, independent of CLK, force state IDLE, dp_in=0, res_valid=0, res_code=0, res_data=0, sum=0, n_res=0, busy=0, done=0, and wait counter=0.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep; after RST_N rises, the first start edge SHALL begin a fresh sweep.

Verification
REQ-032 Full sweep: SETTLE_CYC=1, model dp_out=2*dp_in, start_code=0, end_code=7 -> res pairs (0,0),(1,2)..(7,14) at edges 2,4..16 after the start edge, sum=56, n_res=8, done with the last res_valid.
REQ-033 Wrap: start_code=6, end_code=1 -> res_code sequence 6,7,0,1, n_res=4.
REQ-034 Single code: start_code=end_code=3, SETTLE_CYC=3 -> one res_valid with res_code=3, 4 edges after start, done in the same cycle.
REQ-035 Abort: abort=1 during SETTLE of the third code -> IDLE next edge, n_res=2, done never high, next start accepted.
REQ-036 start pulsed while busy -> no change to the code sequence or timing.
REQ-037 RST_N pulsed low mid-sweep (between edges) -> all outputs reset immediately, busy=0, and a later start sweeps normally.

Source files
------------

// File: rtl/lab3_seq_ctrl_if.sv
// Bundle of sweep-control, datapath and result signals for lab3_seq_ctrl.
// The slave modport is the controller's view; master is the host/datapath side.
interface lab3_seq_ctrl_if;
  logic       start;
  logic       abort;
  logic [2:0] start_code;
  logic [2:0] end_code;
  logic [3:0] dp_out;
  logic [2:0] dp_in;
  logic       res_valid;
  logic [2:0] res_code;
  logic [3:0] res_data;
  logic [6:0] sum;
  logic [3:0] n_res;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, start_code, end_code, dp_out,
    input  dp_in, res_valid, res_code, res_data, sum, n_res, busy, done
  );

  modport slave (
    input  start, abort, start_code, end_code, dp_out,
    output dp_in, res_valid, res_code, res_data, sum, n_res, busy, done
  );
endinterface

// File: rtl/lab3_seq_ctrl.sv
// Code sweep controller: applies codes start..end (mod 8) to a combinational
// datapath, waits SETTLE_CYC cycles per code, then captures and accumulates dp_out.
module lab3_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic            CLK,
  input logic            RST_N,
  lab3_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_dp_in;
  logic [2:0] r_end_code;
  logic [2:0] r_res_code;
  logic [3:0] r_res_data;
  logic [3:0] r_n_res;
  logic [3:0] r_wait;
  logic [6:0] r_sum;
  logic       r_res_valid;

  logic w_accept;
  logic w_capture;
  logic w_settled;
  logic w_last;

  assign w_accept  = (r_state == StIdle) & bus.start & ~bus.abort;
  // abort outranks capture
  assign w_capture = (r_state == StCapture) & ~bus.abort;
  assign w_settled = (r_wait == SettleLast);
  assign w_last    = (r_dp_in == r_end_code);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = StSettle;
      end
      StSettle: begin
        if (bus.abort)      w_state_nxt = StIdle;
        else if (w_settled) w_state_nxt = StCapture;
      end
      StCapture: begin
        if (bus.abort)   w_state_nxt = StIdle;
        else if (w_last) w_state_nxt = StDone;
        else             w_state_nxt = StSettle;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath registers: code pointer, settle counter, result capture and accumulation
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dp_in     <= 3'd0;
      r_end_code  <= 3'd0;
      r_res_code  <= 3'd0;
      r_res_data  <= 4'd0;
      r_n_res     <= 4'd0;
      r_wait      <= 4'd0;
      r_sum       <= 7'd0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_dp_in    <= bus.start_code;
        r_end_code <= bus.end_code;
        r_sum      <= 7'd0;
        r_n_res    <= 4'd0;
        r_wait     <= 4'd0;
      end else if ((r_state == StSettle) && !bus.abort) begin
        r_wait <= r_wait + 4'd1;
      end else if (w_capture) begin
        r_res_data  <= bus.dp_out;
        r_res_code  <= r_dp_in;
        r_res_valid <= 1'b1;
        r_sum       <= r_sum + {3'd0, bus.dp_out};
        r_n_res     <= r_n_res + 4'd1;
        if (!w_last) begin
          // 3-bit add wraps 7 -> 0 for free
          r_dp_in <= r_dp_in + 3'd1;
          r_wait  <= 4'd0;
        end
      end
    end
  end

  // Output decode
  always_comb begin
    bus.busy      = (r_state != StIdle);
    bus.done      = (r_state == StDone);
    bus.dp_in     = r_dp_in;
    bus.res_valid = r_res_valid;
    bus.res_code  = r_res_code;
    bus.res_data  = r_res_data;
    bus.sum       = r_sum;
    bus.n_res     = r_n_res;
  end

endmodule

// File: tb/tb_lab3_seq_ctrl.sv
// Scoreboard bench for lab3_seq_ctrl: two instances (SETTLE_CYC=1 and 3), each
// with its own combinational datapath model and expected-result queue.
module tb_lab3_seq_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  lab3_seq_ctrl_if bus1 ();
  lab3_seq_ctrl_if bus3 ();

  // Datapath models: 2*x and 2*x+1
  assign bus1.dp_out = {bus1.dp_in, 1'b0};
  assign bus3.dp_out = {bus3.dp_in, 1'b1};

  lab3_seq_ctrl #(.SETTLE_CYC(1)) u_dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
  lab3_seq_ctrl #(.SETTLE_CYC(3)) u_dut3 (.CLK(CLK), .RST_N(RST_N), .bus(bus3));

  typedef struct {
    int unsigned code;
    int unsigned data;
    int unsigned edge_n;
    bit          last;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_sum;
  int unsigned exp_n;
  int unsigned last_acc;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result monitors
  always @(negedge CLK) begin
    if (RST_N) begin
      if (bus1.res_valid) begin
        if (q1.size() == 0) check_eq("dut1 unexpected res_valid", bus1.res_valid, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check_eq("dut1 res_code", bus1.res_code, e.code);
          check_eq("dut1 res_data", bus1.res_data, e.data);
          check_eq("dut1 res edge", cyc, e.edge_n);
          check_eq("dut1 done with res", bus1.done, e.last);
        end
      end else if (bus1.done) check_eq("dut1 done without res", bus1.done, 0);
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      if (bus3.res_valid) begin
        if (q3.size() == 0) check_eq("dut3 unexpected res_valid", bus3.res_valid, 0);
        else begin
          exp_t e;
          e = q3.pop_front();
          check_eq("dut3 res_code", bus3.res_code, e.code);
          check_eq("dut3 res_data", bus3.res_data, e.data);
          check_eq("dut3 res edge", cyc, e.edge_n);
          check_eq("dut3 done with res", bus3.done, e.last);
        end
      end else if (bus3.done) check_eq("dut3 done without res", bus3.done, 0);
    end
  end

  // Request a sweep and push the first ncap expected results.
  task automatic launch(input int which, input logic [2:0] sc, input logic [2:0] ec,
                        input int ncap);
    int unsigned n;
    int unsigned s;
    logic [2:0]  c;
    logic [2:0]  diff;
    exp_t        e;
    diff = ec - sc;
    n = int'(diff) + 1;
    s = (which == 1) ? 1 : 3;
    @(negedge CLK);
    last_acc = cyc + 1;
    if (which == 1) begin
      bus1.start = 1'b1; bus1.start_code = sc; bus1.end_code = ec;
    end else begin
      bus3.start = 1'b1; bus3.start_code = sc; bus3.end_code = ec;
    end
    exp_sum = 0;
    exp_n = 0;
    c = sc;
    for (int k = 0; k < int'(n) && k < ncap; k++) begin
      e.code   = c;
      e.data   = (which == 1) ? 2 * c : 2 * c + 1;
      e.edge_n = last_acc + (k + 1) * (s + 1);
      e.last   = (k == int'(n) - 1);
      exp_sum += e.data;
      exp_n++;
      if (which == 1) q1.push_back(e);
      else q3.push_back(e);
      c = c + 3'd1;
    end
    @(negedge CLK);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic drain(input int which, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (((which == 1) ? q1.size() : q3.size()) == 0) break;
      @(negedge CLK);
    end
    check_eq("drain queue empty", (which == 1) ? q1.size() : q3.size(), 0);
    @(negedge CLK);
    if (which == 1) begin
      check_eq("dut1 busy after sweep", bus1.busy, 0);
      check_eq("dut1 sum", bus1.sum, exp_sum);
      check_eq("dut1 n_res", bus1.n_res, exp_n);
    end else begin
      check_eq("dut3 busy after sweep", bus3.busy, 0);
      check_eq("dut3 sum", bus3.sum, exp_sum);
      check_eq("dut3 n_res", bus3.n_res, exp_n);
    end
  endtask

  task automatic check_zero1(input string tag);
    check_eq({tag, " dp_in"}, bus1.dp_in, 0);
    check_eq({tag, " res_valid"}, bus1.res_valid, 0);
    check_eq({tag, " res_code"}, bus1.res_code, 0);
    check_eq({tag, " res_data"}, bus1.res_data, 0);
    check_eq({tag, " sum"}, bus1.sum, 0);
    check_eq({tag, " n_res"}, bus1.n_res, 0);
    check_eq({tag, " busy"}, bus1.busy, 0);
    check_eq({tag, " done"}, bus1.done, 0);
  endtask

  initial begin
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.start_code = 3'd0; bus1.end_code = 3'd0;
    bus3.start = 1'b0; bus3.abort = 1'b0; bus3.start_code = 3'd0; bus3.end_code = 3'd0;
    repeat (3) @(negedge CLK);
    check_zero1("reset dut1");
    check_eq("reset dut3 busy", bus3.busy, 0);
    check_eq("reset dut3 n_res", bus3.n_res, 0);
    check_eq("reset dut3 sum", bus3.sum, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // start with abort held is not accepted
    bus1.start = 1'b1; bus1.abort = 1'b1;
    @(negedge CLK);
    bus1.start = 1'b0; bus1.abort = 1'b0;
    check_eq("start+abort ignored busy", bus1.busy, 0);

    // Full sweep 0..7
    launch(1, 3'd0, 3'd7, 99);
    drain(1, 40);
    check_eq("full dp_in held", bus1.dp_in, 7);
    repeat (3) @(negedge CLK);
    check_eq("hold sum", bus1.sum, 56);
    check_eq("hold n_res", bus1.n_res, 8);
    check_eq("hold res_code", bus1.res_code, 7);
    check_eq("hold res_data", bus1.res_data, 14);
    check_eq("hold dp_in", bus1.dp_in, 7);

    // Wrap 6..1
    launch(1, 3'd6, 3'd1, 99);
    drain(1, 30);

    // Single code, SETTLE_CYC=3
    launch(3, 3'd3, 3'd3, 99);
    drain(3, 20);
    check_eq("single dp_in", bus3.dp_in, 3);

    // Abort during SETTLE of the third code
    launch(1, 3'd0, 3'd7, 2);
    repeat (4) @(negedge CLK);
    bus1.abort = 1'b1;
    @(negedge CLK);
    bus1.abort = 1'b0;
    check_eq("abort busy", bus1.busy, 0);
    check_eq("abort n_res", bus1.n_res, 2);
    check_eq("abort sum", bus1.sum, 2);
    check_eq("abort dp_in", bus1.dp_in, 2);
    check_eq("abort queue", q1.size(), 0);
    repeat (4) @(negedge CLK);
    check_eq("abort stays idle", bus1.busy, 0);
    launch(1, 3'd5, 3'd5, 99);
    drain(1, 20);

    // start pulsed while busy, with different codes on the bus
    launch(1, 3'd1, 3'd4, 99);
    repeat (2) @(negedge CLK);
    bus1.start = 1'b1; bus1.start_code = 3'd6; bus1.end_code = 3'd6;
    @(negedge CLK);
    bus1.start = 1'b0;
    drain(1, 30);

    // Reset pulse between edges mid-sweep
    launch(1, 3'd0, 3'd7, 99);
    repeat (3) @(negedge CLK);
    #1 RST_N = 1'b0;
    #1 check_zero1("midreset dut1");
    q1.delete();
    #1 RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("post reset idle", bus1.busy, 0);
    launch(1, 3'd2, 3'd4, 99);
    drain(1, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
